// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone classic initiator. Each accepted load/store command becomes a
//   single WB cycle against the unified instruction/data memory. Sub-word
//   accesses are steered onto byte lanes, and load data is sign- or
//   zero-extended. A bus error, an ack timeout, a misaligned address or an
//   illegal size produces an error response. Only one transaction is
//   outstanding at a time.
//
// Parameters
//   TIMEOUT       cycles spent in BUS without ack/err before abort (1..65535)
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   cmd_*         command channel (valid/ready), sampled at the accepting edge
//   resp_*        response channel (valid/ready): rdata, err flag, code
//                 (00 ok, 01 wb err, 10 timeout, 11 misaligned/illegal)
//   wb_*          Wishbone classic initiator signals
// ---------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic        cmd_unsigned,
    input  logic [31:0] cmd_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_code,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_reg, state_next;
    logic        cmd_ready_reg, cmd_ready_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [31:0] resp_rdata_reg, resp_rdata_next;
    logic        resp_err_reg, resp_err_next;
    logic [1:0]  resp_code_reg, resp_code_next;
    logic [31:0] wb_adr_reg, wb_adr_next;
    logic [31:0] wb_dat_reg, wb_dat_next;
    logic        wb_we_reg, wb_we_next;
    logic [3:0]  wb_sel_reg, wb_sel_next;
    logic        wb_cyc_reg, wb_cyc_next;
    logic [1:0]  size_reg, size_next;
    logic [1:0]  lo_reg, lo_next;
    logic        uns_reg, uns_next;
    logic [15:0] cnt_reg, cnt_next;

    // Store data replicated across lanes so the slave picks the enabled ones.
    logic [31:0] byte_rep, half_rep, dat_steer;
    logic [3:0]  sel_steer;
    logic        bad_cmd;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_rep
            assign byte_rep[gi*8 +: 8] = cmd_wdata[7:0];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half_rep
            assign half_rep[gi*16 +: 16] = cmd_wdata[15:0];
        end
    endgenerate

    always_comb begin
        sel_steer = 4'b1111;
        dat_steer = cmd_wdata;
        case (cmd_size)
            2'b00: begin
                sel_steer = 4'b0001 << cmd_addr[1:0];
                dat_steer = byte_rep;
            end
            2'b01: begin
                sel_steer = cmd_addr[1] ? 4'b1100 : 4'b0011;
                dat_steer = half_rep;
            end
            default: ;
        endcase
    end

    assign bad_cmd = (cmd_size == 2'b11)
                   | ((cmd_size == 2'b01) & cmd_addr[0])
                   | ((cmd_size == 2'b10) & (|cmd_addr[1:0]));

    // Load extraction: move the addressed lane down to bit 0, then extend.
    logic [31:0] rd_shift, load_data;
    logic [15:0] cnt_inc;

    assign rd_shift = wb_dat_i >> {lo_reg, 3'b000};
    assign cnt_inc  = cnt_reg + 16'd1;

    always_comb begin
        case (size_reg)
            2'b00:   load_data = uns_reg ? {24'd0, rd_shift[7:0]}
                                         : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_data = uns_reg ? {16'd0, rd_shift[15:0]}
                                         : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        resp_valid_next = resp_valid_reg;
        resp_rdata_next = resp_rdata_reg;
        resp_err_next   = resp_err_reg;
        resp_code_next  = resp_code_reg;
        wb_adr_next     = wb_adr_reg;
        wb_dat_next     = wb_dat_reg;
        wb_we_next      = wb_we_reg;
        wb_sel_next     = wb_sel_reg;
        wb_cyc_next     = wb_cyc_reg;
        size_next       = size_reg;
        lo_next         = lo_reg;
        uns_next        = uns_reg;
        cnt_next        = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready_reg) begin
                    size_next = cmd_size;
                    lo_next   = cmd_addr[1:0];
                    uns_next  = cmd_unsigned;
                    if (bad_cmd) begin
                        // Rejected locally: no bus cycle is started.
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                        resp_code_next  = 2'b11;
                        resp_rdata_next = 32'd0;
                        state_next      = RESP;
                    end else begin
                        wb_cyc_next = 1'b1;
                        wb_we_next  = cmd_we;
                        wb_adr_next = {cmd_addr[31:2], 2'b00};
                        wb_sel_next = sel_steer;
                        wb_dat_next = dat_steer;
                        cnt_next    = 16'd0;
                        state_next  = BUS;
                    end
                end
            end
            BUS: begin
                cnt_next = cnt_inc;
                // Timeout fires on the TIMEOUT-th BUS cycle without ack/err.
                if (wb_err_i || wb_ack_i || (cnt_inc == TIMEOUT_CNT)) begin
                    wb_cyc_next     = 1'b0;
                    wb_we_next      = 1'b0;
                    wb_sel_next     = 4'd0;
                    resp_valid_next = 1'b1;
                    state_next      = RESP;
                    if (wb_err_i) begin
                        resp_code_next  = 2'b01;
                        resp_err_next   = 1'b1;
                        resp_rdata_next = 32'd0;
                    end else if (wb_ack_i) begin
                        resp_code_next  = 2'b00;
                        resp_err_next   = 1'b0;
                        resp_rdata_next = wb_we_reg ? 32'd0 : load_data;
                    end else begin
                        resp_code_next  = 2'b10;
                        resp_err_next   = 1'b1;
                        resp_rdata_next = 32'd0;
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_next = 1'b0;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        cmd_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
            resp_code_reg  <= 2'd0;
            wb_adr_reg     <= 32'd0;
            wb_dat_reg     <= 32'd0;
            wb_we_reg      <= 1'b0;
            wb_sel_reg     <= 4'd0;
            wb_cyc_reg     <= 1'b0;
            size_reg       <= 2'd0;
            lo_reg         <= 2'd0;
            uns_reg        <= 1'b0;
            cnt_reg        <= 16'd0;
        end else begin
            state_reg      <= state_next;
            cmd_ready_reg  <= cmd_ready_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_err_reg   <= resp_err_next;
            resp_code_reg  <= resp_code_next;
            wb_adr_reg     <= wb_adr_next;
            wb_dat_reg     <= wb_dat_next;
            wb_we_reg      <= wb_we_next;
            wb_sel_reg     <= wb_sel_next;
            wb_cyc_reg     <= wb_cyc_next;
            size_reg       <= size_next;
            lo_reg         <= lo_next;
            uns_reg        <= uns_next;
            cnt_reg        <= cnt_next;
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign resp_code  = resp_code_reg;
    assign wb_adr_o   = wb_adr_reg;
    assign wb_dat_o   = wb_dat_reg;
    assign wb_we_o    = wb_we_reg;
    assign wb_sel_o   = wb_sel_reg;
    assign wb_cyc_o   = wb_cyc_reg;
    assign wb_stb_o   = wb_cyc_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
//   Directed bench for wb_cmd_master (TIMEOUT=4). Stimulus pushes expected
//   WB cycles and responses into queues; a WB responder/monitor and a
//   response monitor pop and compare on their own.
// ---------------------------------------------------------------------------
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_we, cmd_unsigned;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [1:0]  cmd_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_code;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
    logic [3:0]  wb_sel_o;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_unsigned(cmd_unsigned),
        .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_code(resp_code),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
    } resp_t;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          chk_dat;
        int          cycles;   // 0 = length not checked
    } wb_t;

    resp_t exp_resp_q[$];
    wb_t   exp_wb_q[$];

    int n_vec  = 0;
    int n_fail = 0;

    // Responder behaviour: ack on the resp_k-th cycle of cyc (0 = never).
    int          resp_k   = 1;
    bit          err_mode = 1'b0;
    logic [31:0] mem_word = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // WB responder and cycle monitor
    initial begin : responder
        wb_t cur;
        int  n;
        bit  prev;
        n = 0;
        prev = 1'b0;
        cur = '{adr: 32'd0, we: 1'b0, sel: 4'd0, dat: 32'd0, chk_dat: 1'b0, cycles: 0};
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                prev = 1'b0;
                n = 0;
            end else begin
                if (wb_cyc_o) begin
                    if (!prev) begin
                        if (exp_wb_q.size() == 0) begin
                            n_vec++;
                            n_fail++;
                            $display("FAIL wb_unexpected: cyc asserted adr=%h, expected no cycle", wb_adr_o);
                            cur.cycles = 0;
                        end else begin
                            cur = exp_wb_q.pop_front();
                            check("wb_stb", {31'd0, wb_stb_o}, 32'd1);
                            check("wb_adr", wb_adr_o, cur.adr);
                            check("wb_we", {31'd0, wb_we_o}, {31'd0, cur.we});
                            check("wb_sel", {28'd0, wb_sel_o}, {28'd0, cur.sel});
                            if (cur.chk_dat) check("wb_dat", wb_dat_o, cur.dat);
                        end
                        n = 0;
                    end
                    n++;
                    if (resp_k != 0 && n == resp_k) begin
                        wb_ack_i = 1'b1;
                        wb_err_i = err_mode;
                        wb_dat_i = mem_word;
                    end else begin
                        wb_ack_i = 1'b0;
                        wb_err_i = 1'b0;
                        wb_dat_i = 32'hDEAD_BEEF;
                    end
                end else begin
                    if (prev && cur.cycles != 0) check("wb_cyc_len", n, cur.cycles);
                    wb_ack_i = 1'b0;
                    wb_err_i = 1'b0;
                end
                prev = wb_cyc_o;
            end
        end
    end

    // Response monitor
    initial begin : resp_monitor
        resp_t e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid && resp_ready) begin
                if (exp_resp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL resp_unexpected: rdata=%h code=%0d, expected no response", resp_rdata, resp_code);
                end else begin
                    e = exp_resp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                    check("resp_code", {30'd0, resp_code}, {30'd0, e.code});
                    $display("resp: rdata=%h err=%0d code=%0d", resp_rdata, resp_err, resp_code);
                end
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
        bit got;
        got = 1'b0;
        cmd_valid = 1'b1;
        cmd_we = we;
        cmd_addr = addr;
        cmd_size = size;
        cmd_unsigned = uns;
        cmd_wdata = wdata;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
        end
        n_vec++;
        if (!got) begin
            n_fail++;
            $display("FAIL cmd_accept: cmd_ready never rose, expected accept within 50 cycles");
        end
        @(posedge clk);
        #1;
        // Scramble fields: the DUT must have latched them at the accept edge.
        cmd_valid = 1'b0;
        cmd_we = ~we;
        cmd_addr = 32'hFFFF_FFFF;
        cmd_size = 2'b11;
        cmd_unsigned = ~uns;
        cmd_wdata = 32'h5A5A_5A5A;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (exp_resp_q.size() == 0 && !resp_valid && !wb_cyc_o) done = 1'b1;
        end
        n_vec++;
        if (!done) begin
            n_fail++;
            $display("FAIL idle_wait: %0d responses outstanding, expected 0", exp_resp_q.size());
            exp_resp_q.delete();
            exp_wb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata,
                      input bit has_wb, input logic [3:0] sel, input logic [31:0] dat,
                      input int cycles, input logic [31:0] rdata, input logic [1:0] code);
        $display("cmd: we=%0d addr=%h size=%0d uns=%0d wdata=%h", we, addr, size, uns, wdata);
        if (has_wb)
            exp_wb_q.push_back('{adr: {addr[31:2], 2'b00}, we: we, sel: sel, dat: dat,
                                 chk_dat: we, cycles: cycles});
        exp_resp_q.push_back('{rdata: rdata, err: (code != 2'b00), code: code});
        send(we, addr, size, uns, wdata);
        wait_idle();
    endtask

    initial begin : stimulus
        cmd_valid = 1'b0;
        cmd_we = 1'b0;
        cmd_addr = 32'd0;
        cmd_size = 2'd0;
        cmd_unsigned = 1'b0;
        cmd_wdata = 32'd0;
        resp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_ctrl", {24'd0, cmd_ready, resp_valid, resp_err, resp_code, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        #5 rst = 1'b0;
        @(negedge clk);
        check("rst_ready_low", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("rst_ready_high", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Word store, byte/half/word loads
        resp_k = 1;
        op(1'b1, 32'h0000_1000, 2'b10, 1'b0, 32'h0000_0001, 1'b1, 4'hF, 32'h0000_0001, 1, 32'h0, 2'b00);
        mem_word = 32'h80FF_1234;
        op(1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0, 1'b1, 4'h8, 32'h0, 1, 32'hFFFF_FF80, 2'b00);
        op(1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'h0, 1'b1, 4'h8, 32'h0, 1, 32'h0000_0080, 2'b00);
        resp_k = 3;
        op(1'b0, 32'h0000_0102, 2'b01, 1'b0, 32'h0, 1'b1, 4'hC, 32'h0, 3, 32'hFFFF_80FF, 2'b00);
        op(1'b0, 32'h0000_0100, 2'b01, 1'b1, 32'h0, 1'b1, 4'h3, 32'h0, 3, 32'h0000_1234, 2'b00);
        resp_k = 2;
        op(1'b0, 32'h0000_0104, 2'b10, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0, 2, 32'h80FF_1234, 2'b00);

        // Sub-word stores and locally rejected commands
        resp_k = 1;
        op(1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'h0000_ABCD, 1'b1, 4'hC, 32'hABCD_ABCD, 1, 32'h0, 2'b00);
        op(1'b1, 32'h0000_0005, 2'b00, 1'b0, 32'h1234_5677, 1'b1, 4'h2, 32'h7777_7777, 1, 32'h0, 2'b00);
        op(1'b0, 32'h0000_2001, 2'b01, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 32'h0, 2'b11);
        op(1'b0, 32'h0000_1000, 2'b11, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 0, 32'h0, 2'b11);
        op(1'b1, 32'h0000_1002, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'h0, 32'h0, 0, 32'h0, 2'b11);

        // Timeout, then err together with ack
        resp_k = 0;
        op(1'b0, 32'h0000_3000, 2'b10, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0, 4, 32'h0, 2'b10);
        resp_k = 1;
        err_mode = 1'b1;
        op(1'b0, 32'h0000_3001, 2'b00, 1'b0, 32'h0, 1'b1, 4'h2, 32'h0, 1, 32'h0, 2'b01);
        err_mode = 1'b0;

        // Response back-pressure with a second command waiting
        begin : backpressure
            bit seen;
            resp_ready = 1'b0;
            mem_word = 32'h7F00_0000;
            $display("cmd: we=1 addr=00004000 size=2 wdata=11112222 (resp held)");
            exp_wb_q.push_back('{adr: 32'h4000, we: 1'b1, sel: 4'hF, dat: 32'h1111_2222, chk_dat: 1'b1, cycles: 1});
            exp_resp_q.push_back('{rdata: 32'h0, err: 1'b0, code: 2'b00});
            send(1'b1, 32'h0000_4000, 2'b10, 1'b0, 32'h1111_2222);
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (resp_valid) seen = 1'b1;
            end
            check("bp_resp_seen", {31'd0, seen}, 32'd1);
            @(posedge clk);
            #1;
            $display("cmd: we=0 addr=00004003 size=0 (waiting behind held resp)");
            exp_wb_q.push_back('{adr: 32'h4000, we: 1'b0, sel: 4'h8, dat: 32'h0, chk_dat: 1'b0, cycles: 1});
            exp_resp_q.push_back('{rdata: 32'h0000_007F, err: 1'b0, code: 2'b00});
            cmd_valid = 1'b1;
            cmd_we = 1'b0;
            cmd_addr = 32'h0000_4003;
            cmd_size = 2'b00;
            cmd_unsigned = 1'b0;
            cmd_wdata = 32'h0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("bp_valid", {31'd0, resp_valid}, 32'd1);
                check("bp_fields", {resp_rdata[29:0], resp_err, resp_code[0]} ^ {30'd0, 1'b0, resp_code[1]}, 32'd0);
                check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
                check("bp_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
            end
            @(posedge clk);
            #1;
            resp_ready = 1'b1;
            @(negedge clk);
            check("bp_ready_before_hs", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
            check("bp_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
            check("bp_valid_dropped", {31'd0, resp_valid}, 32'd0);
            @(posedge clk);
            #1;
            check("bp_second_started", {31'd0, wb_cyc_o}, 32'd1);
            cmd_valid = 1'b0;
            cmd_addr = 32'hFFFF_FFFF;
            wait_idle();
        end

        // Asynchronous reset while in BUS
        resp_k = 0;
        $display("cmd: we=0 addr=00005000 size=2 (reset during bus cycle)");
        exp_wb_q.push_back('{adr: 32'h5000, we: 1'b0, sel: 4'hF, dat: 32'h0, chk_dat: 1'b0, cycles: 0});
        send(1'b0, 32'h0000_5000, 2'b10, 1'b0, 32'h0);
        @(negedge clk);
        check("rst6_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst6_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        check("rst6_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        op(1'b0, 32'h0000_6000, 2'b10, 1'b0, 32'h0, 1'b1, 4'hF, 32'h0, 4, 32'h0, 2'b10);

        check("queues_empty", exp_resp_q.size() + exp_wb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
